video_frame_packer: RTL and testbench



---
 rtl/video_frame_packer.sv | 239 +++++++++++++++++++++++
 tb/tb_video_frame_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_packer
//  Description : Packs PIX_W-bit pixels into frame-aligned WORD_W-bit DMA
//                words. Each frame starts with a header word. Partial words
//                are padded with FILL lanes. Words are buffered in a FIFO for
//                the DMA read port. When the FIFO is full, the rest of the
//                frame is dropped. Reads from an empty FIFO return a fill
//                pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module video_frame_packer #(
    parameter int                PIX_W     = 16,
    parameter int                WORD_W    = 128,
    parameter int                DEPTH     = 512,
    parameter logic [PIX_W-1:0]  FILL      = 16'hCCCC,
    parameter logic [31:0]       HDR_MAGIC = 32'hF5A5_0000,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pix_vsync,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       level,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              overflow
);

    localparam int                PPW       = WORD_W / PIX_W;
    localparam int                LW        = $clog2(PPW);
    localparam logic [AW:0]       FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [LW-1:0]     LAST_LANE = LW'(PPW-1);
    localparam logic [WORD_W-1:0] FILL_WORD = {PPW{FILL}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    state_t             state;
    logic               vsync_q;
    logic               hdr_pend;
    logic [LW-1:0]      lane_cnt;
    logic [WORD_W-1:0]  pack_buf;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [WORD_W-1:0]  mem [DEPTH];

    logic               sof;
    logic               pix_ok;
    logic               last_lane;
    logic               full;
    logic [WORD_W-1:0]  word_full;
    logic [WORD_W-1:0]  word_pad;
    logic [WORD_W-1:0]  word_hdr;
    logic               wr_req;
    logic               wr_is_hdr;
    logic [WORD_W-1:0]  wr_word;
    logic               wr_ok;
    logic               wr_drop;
    logic               pop;

    // Frame-sync edge detection and pixel qualification.
    always_comb begin
        sof       = pix_vsync & ~vsync_q;
        pix_ok    = pix_valid & ~pix_vsync;
        last_lane = (lane_cnt == LAST_LANE);
        // Full is judged before any read in the same cycle.
        full      = (level == FULL_LVL);
    end

    // Candidate words: completed word, padded partial word and frame header.
    always_comb begin
        word_full = pack_buf;
        word_pad  = pack_buf;
        for (int k = 0; k < PPW; k++) begin
            if (LW'(k) == lane_cnt) begin
                word_full[k*PIX_W +: PIX_W] = pix_data;
            end
            if (LW'(k) >= lane_cnt) begin
                word_pad[k*PIX_W +: PIX_W] = FILL;
            end
        end
        word_hdr          = '0;
        word_hdr[127:96]  = HDR_MAGIC;
        word_hdr[95:80]   = frame_cnt;
        word_hdr[79:64]   = drop_cnt;
    end

    // Select at most one FIFO write per cycle. A header never coincides with
    // a completed word because the header cycle always sees lane 0.
    always_comb begin
        wr_req    = 1'b0;
        wr_is_hdr = 1'b0;
        wr_word   = word_full;
        if (en && state == ST_STREAM) begin
            if (sof) begin
                if (lane_cnt != '0) begin
                    wr_req  = 1'b1;
                    wr_word = word_pad;
                end
            end else if (hdr_pend) begin
                wr_req    = 1'b1;
                wr_is_hdr = 1'b1;
                wr_word   = word_hdr;
            end else if (pix_ok && last_lane) begin
                wr_req  = 1'b1;
                wr_word = word_full;
            end
        end
        wr_ok   = wr_req & ~full;
        wr_drop = wr_req & full;
        pop     = rd_en & (level != '0) & (state != ST_IDLE);
    end

    // FIFO storage; left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Control FSM, packer, FIFO pointers, counters and read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vsync_q   <= 1'b0;
            hdr_pend  <= 1'b0;
            lane_cnt  <= '0;
            pack_buf  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            rd_data   <= FILL_WORD;
            rd_valid  <= 1'b0;
        end else begin
            vsync_q <= pix_vsync;

            // Read port: pop a stored word, or return fill on an empty read.
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end else if (rd_en) begin
                rd_data <= FILL_WORD;
            end

            // Write side bookkeeping.
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_is_hdr) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (wr_drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt + 1'b1;
            end

            case ({wr_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (state == ST_IDLE) begin
                // Flush FIFO, packer and pending header.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                lane_cnt <= '0;
                pack_buf <= '0;
                hdr_pend <= 1'b0;
                if (en) begin
                    state <= ST_WAIT_SOF;
                end
            end else if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_WAIT_SOF: begin
                        if (sof) begin
                            hdr_pend <= 1'b1;
                            lane_cnt <= '0;
                            state    <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (sof) begin
                            lane_cnt <= '0;
                            if (wr_drop) begin
                                hdr_pend <= 1'b0;
                                state    <= ST_DROP;
                            end else begin
                                hdr_pend <= 1'b1;
                            end
                        end else begin
                            if (hdr_pend) begin
                                hdr_pend <= 1'b0;
                            end
                            if (pix_ok) begin
                                pack_buf <= word_full;
                                if (last_lane) begin
                                    lane_cnt <= '0;
                                end else begin
                                    lane_cnt <= lane_cnt + 1'b1;
                                end
                            end
                            if (wr_drop) begin
                                state <= ST_DROP;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (sof) begin
                            hdr_pend <= 1'b1;
                            lane_cnt <= '0;
                            state    <= ST_STREAM;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_frame_packer
//  Description : Self-checking bench for video_frame_packer (DEPTH=16) using
//                an expected-word queue filled as stimulus is driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_frame_packer;

    localparam int           DEPTH     = 16;
    localparam logic [127:0] FILL_WORD = {8{16'hCCCC}};

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         pix_vsync;
    logic         pix_valid;
    logic [15:0]  pix_data;
    logic         rd_en;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic [4:0]   level;
    logic [15:0]  frame_cnt;
    logic [15:0]  drop_cnt;
    logic         overflow;

    video_frame_packer #(
        .PIX_W     (16),
        .WORD_W    (128),
        .DEPTH     (DEPTH),
        .FILL      (16'hCCCC),
        .HDR_MAGIC (32'hF5A5_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pix_vsync (pix_vsync),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (level),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 = waiting for SOF, 1 = streaming, 2 = dropping.
    logic [127:0] exp_q[$];
    int           m_st;
    int           m_level;
    int           m_lane;
    logic [15:0]  m_frame;
    logic [15:0]  m_drop;
    logic [15:0]  m_buf [8];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_st    = 0;
        m_level = 0;
        m_lane  = 0;
    endtask

    // Model a FIFO write attempt; a full FIFO drops it and the frame.
    task automatic attempt(input logic [127:0] w, input bit is_hdr, output bit ok);
        if (m_level == DEPTH) begin
            m_drop = m_drop + 16'd1;
            m_st   = 2;
            ok     = 1'b0;
        end else begin
            exp_q.push_back(w);
            m_level++;
            if (is_hdr) m_frame = m_frame + 16'd1;
            ok = 1'b1;
        end
    endtask

    task automatic pix(input logic [15:0] d);
        logic [127:0] w;
        bit ok;
        pix_valid = 1'b1;
        pix_data  = d;
        if (m_st == 1) begin
            m_buf[m_lane] = d;
            m_lane++;
            if (m_lane == 8) begin
                for (int k = 0; k < 8; k++) w[k*16 +: 16] = m_buf[k];
                attempt(w, 1'b0, ok);
                m_lane = 0;
            end
        end
        tick();
        pix_valid = 1'b0;
    endtask

    // One-cycle vsync pulse followed by the header cycle.
    task automatic sof();
        logic [127:0] w;
        bit ok;
        bit hdr;
        hdr       = 1'b1;
        pix_vsync = 1'b1;
        pix_valid = 1'b0;
        if (m_st == 1 && m_lane != 0) begin
            for (int k = 0; k < 8; k++) w[k*16 +: 16] = (k < m_lane) ? m_buf[k] : 16'hCCCC;
            attempt(w, 1'b0, ok);
            if (!ok) hdr = 1'b0;
        end
        m_lane = 0;
        tick();
        pix_vsync = 1'b0;
        if (hdr) begin
            m_st = 1;
            w = {32'hF5A5_0000, m_frame, m_drop, 64'h0};
            attempt(w, 1'b1, ok);
        end
        tick();
    endtask

    task automatic rd_one(input string tag);
        logic [127:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            m_level--;
            check({tag, "_valid"}, {127'd0, rd_valid}, 128'd1);
            check({tag, "_data"}, rd_data, exp);
        end else begin
            check({tag, "_valid"}, {127'd0, rd_valid}, 128'd0);
            check({tag, "_data"}, rd_data, FILL_WORD);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        pix_vsync = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        rd_en     = 1'b0;
        m_frame   = '0;
        m_drop    = '0;
        model_clear();

        tick();
        tick();
        check("rst_rd_data",   rd_data, FILL_WORD);
        check("rst_rd_valid",  {127'd0, rd_valid}, 128'd0);
        check("rst_level",     {123'd0, level}, 128'd0);
        check("rst_frame_cnt", {112'd0, frame_cnt}, 128'd0);
        check("rst_drop_cnt",  {112'd0, drop_cnt}, 128'd0);
        check("rst_overflow",  {127'd0, overflow}, 128'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        pix(16'hDEAD);                      // before any SOF: discarded
        check("wait_sof_level", {123'd0, level}, 128'd0);

        // Aligned frame: header plus two full words.
        sof();
        for (int i = 1; i <= 16; i++) pix(16'(i));
        check("aligned_level", {123'd0, level}, 128'd3);
        check("aligned_frame_cnt", {112'd0, frame_cnt}, 128'd1);
        for (int i = 0; i < 3; i++) rd_one("aligned_rd");
        rd_one("empty_rd");

        // Partial word padded at the next SOF, then header for frame 1.
        pix(16'h000A);
        pix(16'h000B);
        pix(16'h000C);
        sof();
        check("partial_level", {123'd0, level}, 128'd2);
        rd_one("pad_rd");
        rd_one("hdr1_rd");

        // Overflow: 20 words of pixels with no reads.
        for (int i = 0; i < 160; i++) pix(16'(16'h0100 + i));
        check("ovf_level",    {123'd0, level}, 128'd16);
        check("ovf_flag",     {127'd0, overflow}, 128'd1);
        check("ovf_drop_cnt", {112'd0, drop_cnt}, 128'd1);
        for (int i = 0; i < 16; i++) rd_one("drain_rd");
        check("drain_level", {123'd0, level}, 128'd0);
        sof();
        for (int i = 0; i < 8; i++) pix(16'(16'h0200 + i));
        check("resume_level", {123'd0, level}, 128'd2);
        rd_one("resume_hdr_rd");
        rd_one("resume_word_rd");
        check("ovf_sticky", {127'd0, overflow}, 128'd1);

        // Disarm mid-frame with five words stored.
        sof();
        for (int i = 0; i < 35; i++) pix(16'(16'h0300 + i));
        check("disarm_pre_level", {123'd0, level}, 128'd5);
        en = 1'b0;
        tick();
        check("disarm_edge1_level", {123'd0, level}, 128'd5);
        tick();
        check("disarm_edge2_level", {123'd0, level}, 128'd0);
        check("disarm_frame_cnt", {112'd0, frame_cnt}, {112'd0, m_frame});
        model_clear();
        pix(16'h0400);
        check("disarm_pix_level", {123'd0, level}, 128'd0);
        rd_one("disarm_empty_rd");
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) pix(16'(16'h0500 + i));
        check("rearm_no_sof_level", {123'd0, level}, 128'd0);
        sof();
        for (int i = 0; i < 8; i++) pix(16'(16'h0600 + i));
        check("rearm_level", {123'd0, level}, 128'd2);
        rd_one("rearm_hdr_rd");
        rd_one("rearm_word_rd");

        // Asynchronous reset in the middle of a frame.
        sof();
        for (int i = 0; i < 8; i++) pix(16'(16'h0700 + i));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_level",     {123'd0, level}, 128'd0);
        check("midrst_rd_data",   rd_data, FILL_WORD);
        check("midrst_rd_valid",  {127'd0, rd_valid}, 128'd0);
        check("midrst_frame_cnt", {112'd0, frame_cnt}, 128'd0);
        check("midrst_drop_cnt",  {112'd0, drop_cnt}, 128'd0);
        check("midrst_overflow",  {127'd0, overflow}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
